// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
// The optional watchdog is enabled with SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    ACTIVE  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Round-robin picker: rotates req so the slot after last is bit 0, takes the
// lowest set bit, then maps the result back to an absolute requester index.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 start;
  int                 sel;

  always_comb begin
    start = (int'(last) + 1) % N_REQ;
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    sel   = 0;
    any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i] && !any) begin
        any = 1'b1;
        sel = i;
      end
    end
    pick_idx = IW'((sel + start) % N_REQ);
    pick     = '0;
    if (any) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmit master among N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a hung transaction.
//
// state   | meaning
// IDLE    | waiting for any req; captures the round-robin winner
// LAUNCH  | gnt + wrt pulse to the master, busy rises
// WAIT_LO | waiting for the master to drop done
// ACTIVE  | waiting for the master to raise done again
// FINISH  | cmplt pulse for the winner
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DW        = DEF_DW,
  parameter int TO_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_w8,
  input  logic [N_REQ-1:0]    req_pe,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    cmplt,
  output logic                err,
  output logic                busy,
  output logic                wrt,
  output logic [DW-1:0]       tx_data,
  output logic                width8,
  output logic                pos_edge,
  input  logic                done
);

  localparam int IW = idx_w(N_REQ);

  state_t           state, state_n;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             any;
  logic             capture;
  logic             timeout;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = idx_w(TO_CYCLES);
  logic [CW-1:0] wd_cnt;

  // Down-counter loaded in LAUNCH; terminal count 0 lands on the TO_CYCLES-th cycle after LAUNCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == LAUNCH) begin
      wd_cnt <= CW'(TO_CYCLES - 1);
    end else if ((state == WAIT_LO || state == ACTIVE) && wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign timeout = (state == WAIT_LO || state == ACTIVE) && (wd_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt     = '0;
    cmplt   = '0;
    wrt     = 1'b0;
    capture = 1'b0;
    busy    = (state != IDLE);
    err     = timeout;
    case (state)
      IDLE: begin
        if (any) begin
          capture = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        gnt[last] = 1'b1;
        wrt       = 1'b1;
        state_n   = WAIT_LO;
      end
      WAIT_LO: if (!done) state_n = ACTIVE;
      ACTIVE:  if (done)  state_n = FINISH;
      FINISH: begin
        cmplt[last] = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IW'(N_REQ - 1);
      tx_data  <= '0;
      width8   <= 1'b0;
      pos_edge <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        last     <= pick_idx;
        tx_data  <= req_data[pick_idx*DW +: DW];
        width8   <= req_w8[pick_idx];
        pos_edge <= req_pe[pick_idx];
      end
    end
  end

endmodule
